// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: CAN falling edge -> TDC arm -> floor average of 2^LOG2_N results.
// Define TDC_TIMEOUT_EN for a WAIT_DONE watchdog that drives err_timeout.
module tdc_meas_ctrl #(
  parameter int DATA_W  = 21,
  parameter int LOG2_N  = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW,
  input  logic              CAN_logic,
  output logic              tdc_arm,
  input  logic              tdc_done,
  input  logic [DATA_W-1:0] tdc_data,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic [LOG2_N:0]   sample_cnt,
  output logic              busy,
  output logic              err_timeout
);
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int N     = 1 << LOG2_N;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    ARM,
    WAIT_DONE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              arm_q, arm_d;
  logic              vld_q, vld_d;
  logic              sync1_q, s2_q, s_prev_q;
  logic              fall;
  logic              last;
  logic              expire;
  logic [ACC_W-1:0]  sum;

  assign fall = s_prev_q & ~s2_q;
  assign sum  = acc_q + ACC_W'(tdc_data);
  assign last = (cnt_q == CNT_W'(N - 1));

`ifdef TDC_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;

  // tdc_done in the expiry cycle wins over the timeout
  assign expire = (state_q == WAIT_DONE) && (tmr_q == '0) && !tdc_done;

  always_comb begin
    tmr_d = tmr_q;
    err_d = err_q | expire;
    if (state_q == ARM) begin
      tmr_d = TMR_W'(TIMEOUT - 1);
    end else if (state_q == WAIT_DONE && tmr_q != '0) begin
      tmr_d = tmr_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    vld_d   = vld_q;
    arm_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (SW) state_d = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (fall) begin
          state_d = ARM;
          arm_d   = 1'b1;
        end else if (!SW) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ARM: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (tdc_done) begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            avg_d   = sum[ACC_W-1:LOG2_N];
            vld_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT_EDGE;
          end
        end else if (expire) begin
          state_d = WAIT_EDGE;
        end
      end
      DONE: begin
        if (avg_ready) begin
          vld_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SW ? WAIT_EDGE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // synchronizer resets recessive so reset release never looks like an edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      avg_q    <= '0;
      arm_q    <= 1'b0;
      vld_q    <= 1'b0;
      sync1_q  <= 1'b1;
      s2_q     <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      avg_q    <= avg_d;
      arm_q    <= arm_d;
      vld_q    <= vld_d;
      sync1_q  <= CAN_logic;
      s2_q     <= sync1_q;
      s_prev_q <= s2_q;
    end
  end

  assign tdc_arm    = arm_q;
  assign avg_data   = avg_q;
  assign avg_valid  = vld_q;
  assign sample_cnt = cnt_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: random batches checked against a sum/N reference model.
// Define TDC_TIMEOUT_EN to also exercise the watchdog with TIMEOUT = 16.
module tb_tdc_meas_ctrl;
  localparam int DW = 21;
  localparam int LN = 3;
  localparam int N  = 1 << LN;
`ifdef TDC_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1023;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sw;
  logic          can;
  logic          arm;
  logic          done;
  logic [DW-1:0] data;
  logic [DW-1:0] avg;
  logic          vld;
  logic          rdy;
  logic [LN:0]   cnt;
  logic          busy;
  logic          err;

  tdc_meas_ctrl #(
    .DATA_W (DW),
    .LOG2_N (LN),
    .TIMEOUT(TO)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .SW         (sw),
    .CAN_logic  (can),
    .tdc_arm    (arm),
    .tdc_done   (done),
    .tdc_data   (data),
    .avg_data   (avg),
    .avg_valid  (vld),
    .avg_ready  (rdy),
    .sample_cnt (cnt),
    .busy       (busy),
    .err_timeout(err)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_err = 0;
  logic [DW-1:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // line low -> arm must appear on the third sampled edge
  task automatic fire_edge();
    int lat;
    lat = 0;
    can = 1'b0;
    do begin
      tick();
      lat++;
    end while (!arm && lat < 20);
    chk("arm_latency", 64'(lat), 64'd3);
    can = 1'b1;
  endtask

  task automatic take_sample(input logic [DW-1:0] d, input bit last);
    fire_edge();
    if ($urandom_range(0, 1) == 1) begin
      done = 1'b1;
      data = DW'($urandom);
    end
    tick();
    done = 1'b0;
    chk("arm_width", 64'(arm), 64'd0);
    repeat ($urandom_range(0, 3)) begin
      rdy = 1'($urandom_range(0, 1));
      tick();
    end
    if ($urandom_range(0, 1) == 1) begin
      can = 1'b0;
      tick();
      tick();
      can = 1'b1;
      repeat (3) tick();
    end
    rdy  = last ? 1'b0 : 1'($urandom_range(0, 1));
    done = 1'b1;
    data = d;
    tick();
    done = 1'b0;
    data = DW'($urandom);
    q.push_back(d);
    chk("sample_cnt", 64'(cnt), 64'(q.size()));
    chk("valid_after_sample", 64'(vld), 64'(last));
  endtask

  task automatic batch(input int mode);
    longint        sum;
    logic [DW-1:0] v;
    logic [DW-1:0] exp;
    q.delete();
    sum = 0;
    for (int i = 0; i < N; i++) begin
      unique case (mode)
        1:       v = DW'(100 + i);
        2:       v = {DW{1'b1}};
        default: v = DW'($urandom);
      endcase
      sum += longint'(v);
      take_sample(v, i == N - 1);
    end
    exp = DW'(sum / N);
    chk("avg_data", 64'(avg), 64'(exp));
    chk("avg_cnt_full", 64'(cnt), 64'(N));
    chk("busy_done", 64'(busy), 64'd1);
    for (int c = 0; c < 5; c++) begin
      can = 1'($urandom_range(0, 1));
      tick();
      chk("bp_no_arm", 64'(arm), 64'd0);
      chk("bp_valid", 64'(vld), 64'd1);
      chk("bp_data", 64'(avg), 64'(exp));
    end
    can = 1'b1;
    repeat (3) begin
      tick();
      chk("bp_no_arm", 64'(arm), 64'd0);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("xfer_valid", 64'(vld), 64'd0);
    chk("xfer_cnt", 64'(cnt), 64'd0);
    chk("xfer_busy", 64'(busy), 64'd1);
    tick();
    chk("single_xfer", 64'(vld), 64'd0);
  endtask

  task automatic reset_mid(input bit at_arm);
    q.delete();
    sw = 1'b1;
    tick();
    repeat (2) take_sample(DW'($urandom), 1'b0);
    fire_edge();
    if (!at_arm) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_arm", 64'(arm), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_valid", 64'(vld), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (5) begin
      sw   = 1'($urandom_range(0, 1));
      can  = 1'($urandom_range(0, 1));
      done = 1'($urandom_range(0, 1));
      rdy  = 1'($urandom_range(0, 1));
      data = DW'($urandom);
      tick();
    end
    chk("reset_arm", 64'(arm), 64'd0);
    chk("reset_valid", 64'(vld), 64'd0);
    chk("reset_data", 64'(avg), 64'd0);
    chk("reset_cnt", 64'(cnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    sw   = 1'b0;
    can  = 1'b1;
    done = 1'b0;
    rdy  = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    can = 1'b0;
    repeat (6) begin
      tick();
      chk("idle_no_arm", 64'(arm), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end
    can = 1'b1;
    repeat (3) tick();

    sw = 1'b1;
    tick();
    chk("enable_busy", 64'(busy), 64'd1);
    batch(1);
    batch(2);
    repeat (4) batch(0);

    q.delete();
    repeat (3) take_sample(DW'($urandom), 1'b0);
    chk("abort_pre_cnt", 64'(cnt), 64'd3);
    sw = 1'b0;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_cnt", 64'(cnt), 64'd0);
    chk("abort_valid", 64'(vld), 64'd0);
    can = 1'b0;
    repeat (6) begin
      tick();
      chk("abort_no_arm", 64'(arm), 64'd0);
    end
    can = 1'b1;
    repeat (3) tick();

    reset_mid(1'b0);
    reset_mid(1'b1);

`ifdef TDC_TIMEOUT_EN
    begin
      int n;
      fire_edge();
      n = 0;
      while (!err && n < 100) begin
        tick();
        n++;
      end
      chk("timeout_cycles", 64'(n), 64'd17);
      chk("timeout_cnt", 64'(cnt), 64'd0);
      chk("timeout_busy", 64'(busy), 64'd1);
      fire_edge();
      tick();
      done = 1'b1;
      data = DW'($urandom);
      tick();
      done = 1'b0;
      chk("timeout_then_cnt", 64'(cnt), 64'd1);
      chk("timeout_sticky", 64'(err), 64'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
